// File: rtl/ras_pkg.sv
// Shared types for the return-address stack: stack operation encoding and
// the decode from raw push/pop enables (empty-stack pop is dropped).
package ras_pkg;

  typedef enum logic [1:0] {
    RAS_NOP,
    RAS_PUSH,
    RAS_POP,
    RAS_REPL
  } ras_op_e;

  // push+pop on an empty stack degrades to a plain push; pop on empty is dropped
  function automatic ras_op_e ras_decode(input logic push, input logic pop, input logic empty);
    ras_op_e op;
    op = RAS_NOP;
    case ({push, pop})
      2'b10:   op = RAS_PUSH;
      2'b01:   op = empty ? RAS_NOP : RAS_POP;
      2'b11:   op = empty ? RAS_PUSH : RAS_REPL;
      default: op = RAS_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ras_ckpt_queue.sv
// In-order checkpoint queue of {ptr, count, data} snapshots with alloc at
// tail, retire at head and truncate-to-id (frees the id and everything younger).
module ras_ckpt_queue #(
  parameter int PTRW  = 3,
  parameter int DW    = 32,
  parameter int NCKPT = 4,
  localparam int CIDW = $clog2(NCKPT)
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            alloc,
  input  logic [PTRW-1:0] alloc_ptr,
  input  logic [PTRW:0]   alloc_cnt,
  input  logic [DW-1:0]   alloc_data,
  input  logic            free,
  input  logic            trunc,
  input  logic [CIDW-1:0] trunc_id,
  output logic [PTRW-1:0] rd_ptr,
  output logic [PTRW:0]   rd_cnt,
  output logic [DW-1:0]   rd_data,
  output logic [CIDW-1:0] tail_id,
  output logic [CIDW:0]   cnt,
  output logic            full
);

  logic [PTRW-1:0] slot_ptr  [NCKPT];
  logic [PTRW:0]   slot_cnt  [NCKPT];
  logic [DW-1:0]   slot_data [NCKPT];

  // head/tail carry one extra wrap bit so that full and empty differ
  logic [CIDW:0]   head, tail, head_nxt, tail_nxt;
  logic [CIDW-1:0] trunc_ofs;
  logic            do_free, do_alloc;

  assign cnt      = tail - head;
  assign full     = (cnt == (CIDW+1)'(NCKPT));
  assign tail_id  = tail[CIDW-1:0];
  assign do_free  = free && (cnt != '0);
  // a retire in the same cycle vacates the slot a full queue would allocate into
  assign do_alloc = alloc && !trunc && (!full || do_free);
  assign trunc_ofs = trunc_id - head[CIDW-1:0];

  assign rd_ptr  = slot_ptr[trunc_id];
  assign rd_cnt  = slot_cnt[trunc_id];
  assign rd_data = slot_data[trunc_id];

  always_comb begin
    head_nxt = head + (CIDW+1)'(do_free);
    tail_nxt = tail + (CIDW+1)'(do_alloc);
    if (trunc) begin
      // offset is taken from the pre-retire head, so tail never lands behind head_nxt
      tail_nxt = head + {1'b0, trunc_ofs};
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < NCKPT; i++) begin
        slot_ptr[i]  <= '0;
        slot_cnt[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      if (do_alloc) begin
        slot_ptr[tail[CIDW-1:0]]  <= alloc_ptr;
        slot_cnt[tail[CIDW-1:0]]  <= alloc_cnt;
        slot_data[tail[CIDW-1:0]] <= alloc_data;
      end
    end
  end

  ckpt_overflow_a: assert property (@(posedge clk) disable iff (!aresetn)
    !(alloc && !trunc && full && !do_free))
    else $warning("checkpoint request dropped: all slots in use");

  rbk_freed_head_a: assert property (@(posedge clk) disable iff (!aresetn)
    !(trunc && do_free && (trunc_id == head[CIDW-1:0])))
    else $error("rollback targets the checkpoint being retired");

endmodule

// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack with push/pop/replace, plus in-order
// checkpoints of post-op {ptr, count, stack[ptr]} restored on rollback.
module ras_ckpt_stack
  import ras_pkg::*;
#(
  parameter int DPT   = 8,
  parameter int DW    = 32,
  parameter int NCKPT = 4,
  localparam int PTRW = $clog2(DPT),
  localparam int CIDW = $clog2(NCKPT)
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_push_en,
  input  logic [DW-1:0]   i_push_data,
  input  logic            i_pop_en,
  output logic [DW-1:0]   o_pop_data,
  output logic            o_empty,
  output logic            o_full,
  output logic [PTRW-1:0] o_stack_ptr,
  input  logic            i_ckpt_en,
  output logic [CIDW-1:0] o_ckpt_id,
  output logic            o_ckpt_full,
  output logic [CIDW:0]   o_ckpt_cnt,
  input  logic            i_ckpt_free,
  input  logic            i_rbk_en,
  input  logic [CIDW-1:0] i_rbk_id
);

  localparam logic [PTRW:0] DEPTH = (PTRW+1)'(DPT);

  logic [DW-1:0]   stack [DPT];
  logic [PTRW-1:0] ptr, ptr_op, ptr_nxt, top_idx, wr_addr;
  logic [PTRW:0]   count, count_op, count_nxt;
  logic [DW-1:0]   wr_data;
  logic            wr_en;
  ras_op_e         op;

  logic [PTRW-1:0] rbk_ptr;
  logic [PTRW:0]   rbk_cnt;
  logic [DW-1:0]   rbk_data;

  assign op      = ras_decode(i_push_en, i_pop_en, o_empty);
  assign top_idx = ptr - PTRW'(1);

  always_comb begin
    ptr_op   = ptr;
    count_op = count;
    wr_en    = 1'b0;
    wr_addr  = ptr;
    wr_data  = i_push_data;
    case (op)
      RAS_PUSH: begin
        ptr_op   = ptr + PTRW'(1);
        count_op = (count == DEPTH) ? count : count + (PTRW+1)'(1);
        wr_en    = 1'b1;
      end
      RAS_POP: begin
        ptr_op   = top_idx;
        count_op = count - (PTRW+1)'(1);
      end
      RAS_REPL: begin
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end
      default: ;
    endcase
    ptr_nxt   = ptr_op;
    count_nxt = count_op;
    // rollback owns the single write port and overrides the normal op
    if (i_rbk_en) begin
      ptr_nxt   = rbk_ptr;
      count_nxt = rbk_cnt;
      wr_en     = 1'b1;
      wr_addr   = rbk_ptr;
      wr_data   = rbk_data;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      ptr   <= ptr_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) stack[wr_addr] <= wr_data;
  end

  // the snapshot slot stack[ptr_op] is never the slot written this cycle
  ras_ckpt_queue #(
    .PTRW  (PTRW),
    .DW    (DW),
    .NCKPT (NCKPT)
  ) u_ckpt_queue (
    .clk        (clk),
    .aresetn    (aresetn),
    .alloc      (i_ckpt_en),
    .alloc_ptr  (ptr_op),
    .alloc_cnt  (count_op),
    .alloc_data (stack[ptr_op]),
    .free       (i_ckpt_free),
    .trunc      (i_rbk_en),
    .trunc_id   (i_rbk_id),
    .rd_ptr     (rbk_ptr),
    .rd_cnt     (rbk_cnt),
    .rd_data    (rbk_data),
    .tail_id    (o_ckpt_id),
    .cnt        (o_ckpt_cnt),
    .full       (o_ckpt_full)
  );

  assign o_pop_data  = stack[top_idx];
  assign o_empty     = (count == '0);
  assign o_full      = (count == DEPTH);
  assign o_stack_ptr = ptr;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Directed bench for ras_ckpt_stack (DPT=4, NCKPT=4) with hand-computed
// expectations for wrap, replace, checkpoint, rollback and reset behaviour.
module tb_ras_ckpt_stack;

  localparam int DPT   = 4;
  localparam int DW    = 32;
  localparam int NCKPT = 4;
  localparam int PTRW  = 2;
  localparam int CIDW  = 2;

  logic            clk;
  logic            aresetn;
  logic            i_push_en;
  logic [DW-1:0]   i_push_data;
  logic            i_pop_en;
  logic [DW-1:0]   o_pop_data;
  logic            o_empty;
  logic            o_full;
  logic [PTRW-1:0] o_stack_ptr;
  logic            i_ckpt_en;
  logic [CIDW-1:0] o_ckpt_id;
  logic            o_ckpt_full;
  logic [CIDW:0]   o_ckpt_cnt;
  logic            i_ckpt_free;
  logic            i_rbk_en;
  logic [CIDW-1:0] i_rbk_id;

  int total = 0;
  int bad   = 0;

  ras_ckpt_stack #(.DPT(DPT), .DW(DW), .NCKPT(NCKPT)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .i_push_en   (i_push_en),
    .i_push_data (i_push_data),
    .i_pop_en    (i_pop_en),
    .o_pop_data  (o_pop_data),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_stack_ptr (o_stack_ptr),
    .i_ckpt_en   (i_ckpt_en),
    .o_ckpt_id   (o_ckpt_id),
    .o_ckpt_full (o_ckpt_full),
    .o_ckpt_cnt  (o_ckpt_cnt),
    .i_ckpt_free (i_ckpt_free),
    .i_rbk_en    (i_rbk_en),
    .i_rbk_id    (i_rbk_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    i_push_en   = 1'b0;
    i_push_data = '0;
    i_pop_en    = 1'b0;
    i_ckpt_en   = 1'b0;
    i_ckpt_free = 1'b0;
    i_rbk_en    = 1'b0;
    i_rbk_id    = '0;
  endtask

  task automatic apply_reset();
    clear_in();
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // drivers: inputs set #1 after an edge, consumed at the next edge, outputs read #1 later
  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    i_push_en   = 1'b1;
    i_push_data = d;
    tick();
  endtask

  task automatic do_pop();
    i_pop_en = 1'b1;
    tick();
  endtask

  task automatic do_ckpt();
    i_ckpt_en = 1'b1;
    tick();
  endtask

  task automatic do_rbk(input logic [CIDW-1:0] id);
    i_rbk_en = 1'b1;
    i_rbk_id = id;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", o_empty); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", o_full); end
    total++; if (o_stack_ptr !== 2'd0) begin bad++; $display("FAIL rst_ptr got=%0d exp=0", o_stack_ptr); end
    total++; if (o_ckpt_id !== 2'd0) begin bad++; $display("FAIL rst_ckpt_id got=%0d exp=0", o_ckpt_id); end
    total++; if (o_ckpt_cnt !== 3'd0) begin bad++; $display("FAIL rst_ckpt_cnt got=%0d exp=0", o_ckpt_cnt); end
    total++; if (o_ckpt_full !== 1'b0) begin bad++; $display("FAIL rst_ckpt_full got=%b exp=0", o_ckpt_full); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] vals [5];
    vals = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D, 32'hE000_000E};
    apply_reset();
    for (int i = 0; i < 5; i++) do_push(vals[i]);
    total++; if (o_full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", o_full); end
    total++; if (o_stack_ptr !== 2'd1) begin bad++; $display("FAIL wrap_ptr got=%0d exp=1", o_stack_ptr); end
    for (int i = 4; i >= 1; i--) begin
      total++;
      if (o_pop_data !== vals[i]) begin bad++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, o_pop_data, vals[i]); end
      do_pop();
    end
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_replace();
    apply_reset();
    do_push(32'h0000_00A1);
    do_push(32'h0000_00B2);
    i_push_en = 1'b1; i_pop_en = 1'b1; i_push_data = 32'h0000_0C33; tick();
    total++; if (o_pop_data !== 32'h0000_0C33) begin bad++; $display("FAIL repl_top got=%h exp=00000c33", o_pop_data); end
    total++; if (o_stack_ptr !== 2'd2) begin bad++; $display("FAIL repl_ptr got=%0d exp=2", o_stack_ptr); end
    do_pop();
    total++; if (o_pop_data !== 32'h0000_00A1) begin bad++; $display("FAIL repl_below got=%h exp=000000a1", o_pop_data); end
    do_pop();
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL repl_cnt2 got=%b exp=1", o_empty); end
    i_push_en = 1'b1; i_pop_en = 1'b1; i_push_data = 32'h0000_0D44; tick();
    total++; if (o_pop_data !== 32'h0000_0D44) begin bad++; $display("FAIL repl_empty_top got=%h exp=00000d44", o_pop_data); end
    total++; if (o_stack_ptr !== 2'd1) begin bad++; $display("FAIL repl_empty_ptr got=%0d exp=1", o_stack_ptr); end
    do_pop();
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL repl_empty_cnt1 got=%b exp=1", o_empty); end
  endtask

  task automatic test_rollback();
    apply_reset();
    do_push(32'h1111_0001);
    do_ckpt();
    total++; if (o_ckpt_cnt !== 3'd1) begin bad++; $display("FAIL rbk_cnt_taken got=%0d exp=1", o_ckpt_cnt); end
    do_push(32'h2222_0002);
    total++; if (o_stack_ptr !== 2'd2) begin bad++; $display("FAIL rbk_ptr_wrong got=%0d exp=2", o_stack_ptr); end
    do_rbk(2'd0);
    total++; if (o_stack_ptr !== 2'd1) begin bad++; $display("FAIL rbk_ptr got=%0d exp=1", o_stack_ptr); end
    total++; if (o_pop_data !== 32'h1111_0001) begin bad++; $display("FAIL rbk_top got=%h exp=11110001", o_pop_data); end
    total++; if (o_ckpt_cnt !== 3'd0) begin bad++; $display("FAIL rbk_ckpt_cnt got=%0d exp=0", o_ckpt_cnt); end
    total++; if (o_ckpt_id !== 2'd0) begin bad++; $display("FAIL rbk_ckpt_id got=%0d exp=0", o_ckpt_id); end
    do_pop();
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL rbk_count1 got=%b exp=1", o_empty); end
  endtask

  // seven pushes leave stack=[v4,v5,v6,v3], ptr=3; the wrong-path push clobbers slot 3
  task automatic test_repair();
    apply_reset();
    for (int i = 0; i < 7; i++) do_push(32'h5000_0000 + DW'(i));
    total++; if (o_stack_ptr !== 2'd3) begin bad++; $display("FAIL rep_ptr7 got=%0d exp=3", o_stack_ptr); end
    do_ckpt();
    do_push(32'hDEAD_BEEF);
    total++; if (o_pop_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rep_wrong_top got=%h exp=deadbeef", o_pop_data); end
    do_rbk(2'd0);
    total++; if (o_pop_data !== 32'h5000_0006) begin bad++; $display("FAIL rep_top got=%h exp=50000006", o_pop_data); end
    do_pop();
    do_pop();
    do_pop();
    total++; if (o_pop_data !== 32'h5000_0003) begin bad++; $display("FAIL rep_slot got=%h exp=50000003", o_pop_data); end
    total++; if (o_empty !== 1'b0) begin bad++; $display("FAIL rep_count got=%b exp=0", o_empty); end
  endtask

  task automatic test_multi_ckpt();
    apply_reset();
    do_push(32'h0000_AAAA);
    do_ckpt();
    i_push_en = 1'b1; i_push_data = 32'h0000_BBBB; i_ckpt_en = 1'b1; tick();
    do_push(32'h0000_CCCC);
    do_ckpt();
    do_push(32'h0000_DDDD);
    total++; if (o_ckpt_cnt !== 3'd3) begin bad++; $display("FAIL mc_cnt got=%0d exp=3", o_ckpt_cnt); end
    total++; if (o_full !== 1'b1) begin bad++; $display("FAIL mc_full got=%b exp=1", o_full); end
    do_rbk(2'd1);
    total++; if (o_stack_ptr !== 2'd2) begin bad++; $display("FAIL mc_ptr got=%0d exp=2", o_stack_ptr); end
    total++; if (o_pop_data !== 32'h0000_BBBB) begin bad++; $display("FAIL mc_top got=%h exp=0000bbbb", o_pop_data); end
    total++; if (o_ckpt_cnt !== 3'd1) begin bad++; $display("FAIL mc_ckpt_cnt got=%0d exp=1", o_ckpt_cnt); end
    total++; if (o_ckpt_id !== 2'd1) begin bad++; $display("FAIL mc_ckpt_id got=%0d exp=1", o_ckpt_id); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL mc_notfull got=%b exp=0", o_full); end
    do_pop();
    do_pop();
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL mc_count2 got=%b exp=1", o_empty); end
  endtask

  task automatic test_ckpt_full();
    apply_reset();
    for (int i = 0; i < 4; i++) do_ckpt();
    total++; if (o_ckpt_full !== 1'b1) begin bad++; $display("FAIL cf_full got=%b exp=1", o_ckpt_full); end
    total++; if (o_ckpt_cnt !== 3'd4) begin bad++; $display("FAIL cf_cnt got=%0d exp=4", o_ckpt_cnt); end
    do_ckpt();
    total++; if (o_ckpt_cnt !== 3'd4) begin bad++; $display("FAIL cf_over_cnt got=%0d exp=4", o_ckpt_cnt); end
    total++; if (o_ckpt_id !== 2'd0) begin bad++; $display("FAIL cf_over_id got=%0d exp=0", o_ckpt_id); end
    i_ckpt_en = 1'b1; i_ckpt_free = 1'b1; tick();
    total++; if (o_ckpt_cnt !== 3'd4) begin bad++; $display("FAIL cf_freealloc_cnt got=%0d exp=4", o_ckpt_cnt); end
    total++; if (o_ckpt_id !== 2'd1) begin bad++; $display("FAIL cf_freealloc_id got=%0d exp=1", o_ckpt_id); end
    i_ckpt_free = 1'b1; tick();
    total++; if (o_ckpt_cnt !== 3'd3) begin bad++; $display("FAIL cf_free_cnt got=%0d exp=3", o_ckpt_cnt); end
    total++; if (o_ckpt_full !== 1'b0) begin bad++; $display("FAIL cf_free_full got=%b exp=0", o_ckpt_full); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_push(32'h7777_0007);
    do_ckpt();
    i_push_en = 1'b1; i_push_data = 32'h8888_0008; i_ckpt_en = 1'b1;
    i_rbk_en = 1'b1; i_rbk_id = 2'd0; tick();
    total++; if (o_stack_ptr !== 2'd1) begin bad++; $display("FAIL b2b_ptr got=%0d exp=1", o_stack_ptr); end
    total++; if (o_pop_data !== 32'h7777_0007) begin bad++; $display("FAIL b2b_top got=%h exp=77770007", o_pop_data); end
    total++; if (o_ckpt_cnt !== 3'd0) begin bad++; $display("FAIL b2b_ckpt_cnt got=%0d exp=0", o_ckpt_cnt); end
    total++; if (o_ckpt_id !== 2'd0) begin bad++; $display("FAIL b2b_ckpt_id got=%0d exp=0", o_ckpt_id); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_push(32'h0000_0101);
    do_push(32'h0000_0202);
    do_ckpt();
    #2;
    aresetn = 1'b0;
    #1;
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL ar_empty got=%b exp=1", o_empty); end
    total++; if (o_stack_ptr !== 2'd0) begin bad++; $display("FAIL ar_ptr got=%0d exp=0", o_stack_ptr); end
    total++; if (o_ckpt_cnt !== 3'd0) begin bad++; $display("FAIL ar_ckpt_cnt got=%0d exp=0", o_ckpt_cnt); end
    total++; if (o_ckpt_id !== 2'd0) begin bad++; $display("FAIL ar_ckpt_id got=%0d exp=0", o_ckpt_id); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL ar_full got=%b exp=0", o_full); end
    total++; if (o_ckpt_full !== 1'b0) begin bad++; $display("FAIL ar_ckpt_full got=%b exp=0", o_ckpt_full); end
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    aresetn = 1'b0;
    test_reset();
    test_wrap();
    test_replace();
    test_rollback();
    test_repair();
    test_multi_ckpt();
    test_ckpt_full();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
